// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencing controller: state encoding
// and a sizing helper for the shared cycle counter.
package pll_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: power-on hold, lock wait with timeout and retries,
// lock stability qualification. Macro PLL_LOCK_CTRL_RELOCK_EN selects relock on lock loss.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               clkin,
  input  logic                               reset,
  input  logic                               lock_in,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               rst_out,
  output logic                               locked,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [STATE_W-1:0]                 state_dbg
);

  localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW      = $clog2(MAX_RETRIES+1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry_nxt;
  logic          lock_s;
  logic          pll_reset_nxt, rst_out_nxt, locked_nxt, fail_nxt;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock_in),
    .q   (lock_s)
  );

  // Outputs are decoded from the next state so they update on the same edge as state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      rst_out   <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_reset <= pll_reset_nxt;
      rst_out   <= rst_out_nxt;
      locked    <= locked_nxt;
      fail      <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (restart) begin
      state_nxt = HOLD;
      retry_nxt = '0;
    end else begin
      case (state)
        HOLD: if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TMO_LAST) begin
            if (retry_cnt == RETRY_LAST) begin
              state_nxt = FAIL;
            end else begin
              state_nxt = HOLD;
              retry_nxt = retry_cnt + 1'b1;
            end
          end
        end
        STABLE: begin
          if (!lock_s)                  state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_nxt = RUN;
        end
        RUN: begin
          if (!lock_s) begin
`ifdef PLL_LOCK_CTRL_RELOCK_EN
            state_nxt = HOLD;
            retry_nxt = '0;
`else
            state_nxt = FAIL;
`endif
          end
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = HOLD;
      endcase
    end

    // Restart into HOLD from HOLD still counts as a fresh entry.
    if (restart || (state_nxt != state)) cnt_nxt = '0;
    else if (&cnt)                       cnt_nxt = cnt;
    else                                 cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    pll_reset_nxt = 1'b1;
    rst_out_nxt   = 1'b1;
    locked_nxt    = 1'b0;
    fail_nxt      = 1'b0;
    case (state_nxt)
      WAIT_LOCK, STABLE: pll_reset_nxt = 1'b0;
      RUN: begin
        pll_reset_nxt = 1'b0;
        rst_out_nxt   = 1'b0;
        locked_nxt    = 1'b1;
      end
      FAIL:    fail_nxt = 1'b1;
      default: pll_reset_nxt = 1'b1;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed table-driven bench for pll_lock_ctrl with small timing parameters.
module tb_pll_lock_ctrl;

  localparam int ST_HOLD   = 0;
  localparam int ST_WAIT   = 1;
  localparam int ST_STABLE = 2;
  localparam int ST_RUN    = 3;
  localparam int ST_FAIL   = 4;

  logic       clkin   = 1'b0;
  logic       reset   = 1'b1;
  logic       lock_in = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, rst_out, locked, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  pll_lock_ctrl #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock_in   (lock_in),
    .restart   (restart),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    string       name;
    bit          rst;
    bit          lock;
    bit          rstrt;
    int unsigned step;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] E(input bit pr, input bit ro, input bit lk, input bit fl,
                                   input int r, input int st);
    return {pr, ro, lk, fl, 2'(r), 3'(st)};
  endfunction

  function automatic void add(input string n, input bit rs, input bit lk, input bit rt,
                              input int unsigned s, input logic [8:0] e);
    vec_t v;
    v.name = n; v.rst = rs; v.lock = lk; v.rstrt = rt; v.step = s; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string n, input logic [8:0] exp);
    logic [8:0] got;
    got = {pll_reset, rst_out, locked, fail, retry_cnt, state_dbg};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pll_reset=%b rst_out=%b locked=%b fail=%b retry=%0d state=%0d ; want pll_reset=%b rst_out=%b locked=%b fail=%b retry=%0d state=%0d",
               n, got[8], got[7], got[6], got[5], got[4:3], got[2:0],
               exp[8], exp[7], exp[6], exp[5], exp[4:3], exp[2:0]);
    end
  endtask

  initial begin
    // Sequence 1: normal lock, then lock loss in RUN
    add("s1_reset",     1, 0, 0, 0,  E(1,1,0,0,0,ST_HOLD));
    add("s1_hold3",     0, 0, 0, 3,  E(1,1,0,0,0,ST_HOLD));
    add("s1_wait",      0, 0, 0, 1,  E(0,1,0,0,0,ST_WAIT));
    add("s1_wait5",     0, 0, 0, 5,  E(0,1,0,0,0,ST_WAIT));
    add("s1_rise10",    0, 1, 0, 10, E(0,1,0,0,0,ST_STABLE));
    add("s1_rise11",    0, 1, 0, 1,  E(0,0,1,0,0,ST_RUN));
    add("s4_drop2",     0, 0, 0, 2,  E(0,0,1,0,0,ST_RUN));
`ifdef PLL_LOCK_CTRL_RELOCK_EN
    add("s4_drop3",     0, 0, 0, 1,  E(1,1,0,0,0,ST_HOLD));
    add("s4_hold4",     0, 0, 0, 3,  E(1,1,0,0,0,ST_HOLD));
    add("s4_rewait",    0, 0, 0, 1,  E(0,1,0,0,0,ST_WAIT));
    add("s4_relock",    0, 1, 0, 11, E(0,0,1,0,0,ST_RUN));
`else
    add("s4_drop3",     0, 0, 0, 1,  E(1,1,0,1,0,ST_FAIL));
    add("s4_failhold",  0, 0, 0, 5,  E(1,1,0,1,0,ST_FAIL));
`endif
    // Sequence 2: no lock, retries exhaust into FAIL, then restart
    add("s2_reset",     1, 0, 0, 0,  E(1,1,0,0,0,ST_HOLD));
    add("s2_hold3",     0, 0, 0, 3,  E(1,1,0,0,0,ST_HOLD));
    add("s2_wait0",     0, 0, 0, 1,  E(0,1,0,0,0,ST_WAIT));
    add("s2_wait0_end", 0, 0, 0, 19, E(0,1,0,0,0,ST_WAIT));
    add("s2_tmo1",      0, 0, 0, 1,  E(1,1,0,0,1,ST_HOLD));
    add("s2_wait1",     0, 0, 0, 4,  E(0,1,0,0,1,ST_WAIT));
    add("s2_tmo2",      0, 0, 0, 20, E(1,1,0,0,2,ST_HOLD));
    add("s2_wait2",     0, 0, 0, 4,  E(0,1,0,0,2,ST_WAIT));
    add("s2_edge71",    0, 0, 0, 19, E(0,1,0,0,2,ST_WAIT));
    add("s2_fail72",    0, 0, 0, 1,  E(1,1,0,1,2,ST_FAIL));
    add("s2_fail80",    0, 0, 0, 8,  E(1,1,0,1,2,ST_FAIL));
    add("s5_restart",   0, 0, 1, 1,  E(1,1,0,0,0,ST_HOLD));
    add("s5_hold3",     0, 0, 0, 2,  E(1,1,0,0,0,ST_HOLD));
    add("s5_rise10",    0, 1, 0, 10, E(0,1,0,0,0,ST_STABLE));
    add("s5_rise11",    0, 1, 0, 1,  E(0,0,1,0,0,ST_RUN));
    // Sequence 3: one timeout, then a one-cycle lock glitch during STABLE
    add("s3_reset",     1, 0, 0, 0,  E(1,1,0,0,0,ST_HOLD));
    add("s3_tmo1",      0, 0, 0, 24, E(1,1,0,0,1,ST_HOLD));
    add("s3_wait",      0, 0, 0, 4,  E(0,1,0,0,1,ST_WAIT));
    add("s3_stable",    0, 1, 0, 3,  E(0,1,0,0,1,ST_STABLE));
    add("s3_stable3",   0, 1, 0, 3,  E(0,1,0,0,1,ST_STABLE));
    add("s3_glitch_lo", 0, 0, 0, 1,  E(0,1,0,0,1,ST_STABLE));
    add("s3_glitch_hi", 0, 1, 0, 1,  E(0,1,0,0,1,ST_STABLE));
    add("s3_back_wait", 0, 1, 0, 1,  E(0,1,0,0,1,ST_WAIT));
    add("s3_restable",  0, 1, 0, 1,  E(0,1,0,0,1,ST_STABLE));
    add("s3_rise10",    0, 1, 0, 7,  E(0,1,0,0,1,ST_STABLE));
    add("s3_rise11",    0, 1, 0, 1,  E(0,0,1,0,1,ST_RUN));
    // Lock arriving on the timeout cycle wins over the retry
    add("tmo_reset",    1, 0, 0, 0,  E(1,1,0,0,0,ST_HOLD));
    add("tmo_wait21",   0, 0, 0, 21, E(0,1,0,0,0,ST_WAIT));
    add("tmo_lockwins", 0, 1, 0, 3,  E(0,1,0,0,0,ST_STABLE));

    @(negedge clkin);
    foreach (vecs[i]) begin
      lock_in = vecs[i].lock;
      restart = vecs[i].rstrt;
      if (vecs[i].rst) begin
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
      end
      repeat (vecs[i].step) @(negedge clkin);
      check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in the middle of WAIT_LOCK
    lock_in = 1'b0;
    restart = 1'b0;
    reset   = 1'b1;
    @(negedge clkin);
    reset = 1'b0;
    repeat (6) @(negedge clkin);
    check("ar_wait", E(0,1,0,0,0,ST_WAIT));
    @(posedge clkin);
    #2 reset = 1'b1;
    #1 check("ar_async", E(1,1,0,0,0,ST_HOLD));
    @(negedge clkin);
    reset = 1'b0;
    repeat (4) @(negedge clkin);
    check("ar_rewait", E(0,1,0,0,0,ST_WAIT));

    // Restart has priority while in STABLE
    lock_in = 1'b1;
    repeat (3) @(negedge clkin);
    check("rs_stable", E(0,1,0,0,0,ST_STABLE));
    restart = 1'b1;
    @(negedge clkin);
    restart = 1'b0;
    check("rs_hold", E(1,1,0,0,0,ST_HOLD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
